// File: rtl/flash_arbiter.sv
// flash_arbiter: shares one SPI flash between an instruction-fetch reader
// (port 0) and a data/DMA reader (port 1). Each grant runs a single-bit
// READ (0x03) with a 24-bit address and returns four bytes as a
// little-endian 32-bit word. Ties alternate between the two ports.
module flash_arbiter #(
    parameter int CLK_DIV = 1,
    parameter int ADDR_W  = 24
) (
    input  logic              ck,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack0,
    output logic              ack1,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              spi_sck,
    output logic              spi_cs,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    // Divider counter counts 0..CLK_DIV-1 within one SCK half-period.
    localparam int              CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [7:0]      CMD_READ = 8'h03;
    localparam logic [5:0]      LAST_BIT = 6'd63;
    localparam logic [5:0]      LAST_OUT = 6'd31;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE,
        GAP
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [5:0]      bit_cnt;
    logic            pri;        // port that wins the next tie
    logic            gnt;        // port currently being served
    logic [31:0]     shreg;      // cmd+addr going out, read data coming in
    logic [1:0]      rst_sync;
    logic            rst_int_n;

    logic            win;
    logic            start;
    logic            phase_end;
    logic            bit_end;
    logic            rx_bit;
    logic [31:0]     shreg_next;

    // Address bits above 24 are dropped; narrower addresses zero-extend.
    function automatic logic [23:0] to_addr24(input logic [ADDR_W-1:0] a);
        return 24'(a);
    endfunction

    // First received byte sits in the top of the shift word; it belongs in
    // rdata[7:0], so the byte order is reversed on the way out.
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Reset asserts immediately and releases on a clock edge.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    // Tie goes to the port not served last; a lone request simply wins.
    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
            win = pri;
        end else begin
            win = req1;
        end
    end

    assign start      = (state == IDLE) && (req0 || req1);
    assign phase_end  = (cnt == CNT_LAST);
    // A bit ends on the last cycle of its high phase, where SCK falls.
    assign bit_end    = (state == SHIFT) && phase_end && spi_sck;
    // Only the second half of the frame carries flash data.
    assign rx_bit     = bit_cnt[5] ? spi_miso : 1'b0;
    assign shreg_next = {shreg[30:0], rx_bit};

    // Shift word: loaded with {READ, addr} at grant, shifts once per bit.
    always_ff @(posedge ck) begin
        if (start) begin
            shreg <= {CMD_READ, win ? to_addr24(addr1) : to_addr24(addr0)};
        end else if (bit_end) begin
            shreg <= shreg_next;
        end
    end

    // Transfer sequencer with registered SPI pins, acks, rdata and busy.
    always_ff @(posedge ck or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            pri      <= 1'b0;
            gnt      <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata    <= '0;
            busy     <= 1'b0;
            spi_sck  <= 1'b0;
            spi_cs   <= 1'b1;
            spi_mosi <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    spi_cs  <= 1'b1;
                    spi_sck <= 1'b0;
                    if (start) begin
                        gnt      <= win;
                        pri      <= ~win;
                        busy     <= 1'b1;
                        spi_cs   <= 1'b0;
                        spi_mosi <= CMD_READ[7];
                        cnt      <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_end) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (!phase_end) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                        end else begin
                            spi_sck <= 1'b0;
                            if (bit_cnt == LAST_BIT) begin
                                spi_cs   <= 1'b1;
                                spi_mosi <= 1'b0;
                                rdata    <= byte_swap(shreg_next);
                                ack0     <= ~gnt;
                                ack1     <= gnt;
                                state    <= DONE;
                            end else begin
                                bit_cnt  <= bit_cnt + 1'b1;
                                // Next outgoing bit is the one below the
                                // current MSB; the read phase drives zero.
                                spi_mosi <= (bit_cnt < LAST_OUT) ? shreg[30] : 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    cnt   <= '0;
                    state <= GAP;
                end
                GAP: begin
                    if (phase_end) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter: two instances (CLK_DIV=1 and 3), each
// wired to a small behavioural SPI flash.
`define CHK(TAG, OBS, EXP) begin n_cmp++; assert ((OBS) === (EXP)) else begin n_err++; $error("FAIL %s: observed 'h%0h expected 'h%0h", TAG, (OBS), (EXP)); end end

module tb_flash_arbiter;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic rst_n;

    logic        req0_a, req1_a, ack0_a, ack1_a, busy_a, sck_a, cs_a, mosi_a;
    logic [23:0] addr0_a, addr1_a;
    logic [31:0] rdata_a;
    logic        miso_a = 1'b0;

    logic        req0_b, req1_b, ack0_b, ack1_b, busy_b, sck_b, cs_b, mosi_b;
    logic [23:0] addr0_b, addr1_b;
    logic [31:0] rdata_b;
    logic        miso_b = 1'b0;

    flash_arbiter #(.CLK_DIV(1), .ADDR_W(24)) dut_a (
        .ck(ck), .rst_n(rst_n),
        .req0(req0_a), .req1(req1_a), .addr0(addr0_a), .addr1(addr1_a),
        .ack0(ack0_a), .ack1(ack1_a), .rdata(rdata_a), .busy(busy_a),
        .spi_sck(sck_a), .spi_cs(cs_a), .spi_mosi(mosi_a), .spi_miso(miso_a)
    );

    flash_arbiter #(.CLK_DIV(3), .ADDR_W(24)) dut_b (
        .ck(ck), .rst_n(rst_n),
        .req0(req0_b), .req1(req1_b), .addr0(addr0_b), .addr1(addr1_b),
        .ack0(ack0_b), .ack1(ack1_b), .rdata(rdata_b), .busy(busy_b),
        .spi_sck(sck_b), .spi_cs(cs_b), .spi_mosi(mosi_b), .spi_miso(miso_b)
    );

    // Flash contents: four known bytes at 0x100, a simple pattern elsewhere.
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            default:    return a[7:0] ^ a[15:8] ^ 8'hC3;
        endcase
    endfunction

    // Flash A: captures cmd+addr on rising SCK, drives data after falling SCK.
    int          fcnt_a = 0;
    logic [31:0] fcmd_a = '0;
    always @(posedge sck_a or posedge cs_a) begin
        if (cs_a) begin
            fcnt_a = 0;
        end else begin
            if (fcnt_a < 32) fcmd_a = {fcmd_a[30:0], mosi_a};
            fcnt_a = fcnt_a + 1;
        end
    end
    always @(negedge sck_a) begin : flash_a_out
        int j;
        logic [7:0] bv;
        if (!cs_a && fcnt_a >= 32 && fcnt_a < 64) begin
            j  = fcnt_a - 32;
            bv = mem_byte(fcmd_a[23:0] + 24'(j / 8));
            #1 miso_a = bv[7 - (j % 8)];
        end
    end

    int          fcnt_b = 0;
    logic [31:0] fcmd_b = '0;
    always @(posedge sck_b or posedge cs_b) begin
        if (cs_b) begin
            fcnt_b = 0;
        end else begin
            if (fcnt_b < 32) fcmd_b = {fcmd_b[30:0], mosi_b};
            fcnt_b = fcnt_b + 1;
        end
    end
    always @(negedge sck_b) begin : flash_b_out
        int j;
        logic [7:0] bv;
        if (!cs_b && fcnt_b >= 32 && fcnt_b < 64) begin
            j  = fcnt_b - 32;
            bv = mem_byte(fcmd_b[23:0] + 24'(j / 8));
            #1 miso_b = bv[7 - (j % 8)];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    int          o_cyc, o_port, o_cs_low, o_rise, o_overlap, o_busy_err;
    int          o_hi_min, o_hi_max, o_lo_min, o_lo_max, o_n_hi, o_n_lo, o_first_lo;
    logic [31:0] o_rdata;
    int          t0_cyc;

    // Walks forward one negedge at a time (cycle i) until an ack or budget.
    task automatic observe(input int sel, input int budget);
        logic c, s, a0, a1, b, prev_s;
        int   hi_run, lo_run;
        bit   first;
        o_cyc = 0; o_port = -1; o_cs_low = 0; o_rise = 0; o_overlap = 0; o_busy_err = 0;
        o_hi_min = 1000; o_hi_max = 0; o_lo_min = 1000; o_lo_max = 0;
        o_n_hi = 0; o_n_lo = 0; o_first_lo = 0; o_rdata = '0;
        hi_run = 0; lo_run = 0; first = 1'b1;
        prev_s = (sel != 0) ? sck_b : sck_a;
        for (int i = 1; i <= budget; i++) begin
            @(negedge ck);
            c  = (sel != 0) ? cs_b   : cs_a;
            s  = (sel != 0) ? sck_b  : sck_a;
            a0 = (sel != 0) ? ack0_b : ack0_a;
            a1 = (sel != 0) ? ack1_b : ack1_a;
            b  = (sel != 0) ? busy_b : busy_a;
            if (a0 && a1) o_overlap++;
            if (!c && !b) o_busy_err++;
            if (!c) o_cs_low++;
            if (s && !prev_s) begin
                o_rise++;
                if (first) begin
                    o_first_lo = lo_run;
                end else begin
                    o_n_lo++;
                    if (lo_run < o_lo_min) o_lo_min = lo_run;
                    if (lo_run > o_lo_max) o_lo_max = lo_run;
                end
                first  = 1'b0;
                lo_run = 0;
                hi_run = 1;
            end else if (!s && prev_s) begin
                o_n_hi++;
                if (hi_run < o_hi_min) o_hi_min = hi_run;
                if (hi_run > o_hi_max) o_hi_max = hi_run;
                hi_run = 0;
                lo_run = c ? 0 : 1;
            end else if (s) begin
                hi_run++;
            end else if (!c) begin
                lo_run++;
            end
            prev_s = s;
            if (a0 || a1) begin
                o_cyc   = i;
                o_port  = a0 ? 0 : 1;
                o_rdata = (sel != 0) ? rdata_b : rdata_a;
                break;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req0_a = 0; req1_a = 0; addr0_a = '0; addr1_a = '0;
        req0_b = 0; req1_b = 0; addr0_b = '0; addr1_b = '0;
        repeat (3) @(negedge ck);

        // Reset state
        `CHK("rst_cs", cs_a, 1'b1)
        `CHK("rst_sck", sck_a, 1'b0)
        `CHK("rst_mosi", mosi_a, 1'b0)
        `CHK("rst_ack", {ack0_a, ack1_a}, 2'b00)
        `CHK("rst_rdata", rdata_a, 32'h0)
        `CHK("rst_busy", busy_a, 1'b0)
        `CHK("rst_cs_b", cs_b, 1'b1)
        rst_n = 1'b1;
        repeat (4) @(negedge ck);

        // Single read at 0x000100, D=1
        addr0_a = 24'h000100; req0_a = 1'b1;
        observe(0, 200);
        req0_a = 1'b0;
        `CHK("single_ack_cycle", o_cyc, 130)
        `CHK("single_port", o_port, 0)
        `CHK("single_rdata", o_rdata, 32'h44332211)
        `CHK("single_sck_rises", o_rise, 64)
        `CHK("single_cs_low", o_cs_low, 129)
        `CHK("single_mosi_cmd", fcmd_a, 32'h03000100)
        `CHK("single_busy_cs", o_busy_err, 0)
        @(negedge ck);
        `CHK("gap_busy", busy_a, 1'b1)
        `CHK("gap_cs", cs_a, 1'b1)
        @(negedge ck);
        `CHK("idle_busy", busy_a, 1'b0)
        `CHK("rdata_hold", rdata_a, 32'h44332211)

        // Tie right after reset: port 0 first, then port 1
        rst_n = 1'b0;
        @(negedge ck);
        rst_n = 1'b1;
        repeat (4) @(negedge ck);
        addr0_a = 24'h000200; addr1_a = 24'h000300;
        req0_a = 1'b1; req1_a = 1'b1;
        observe(0, 200);
        req0_a = 1'b0;
        `CHK("tie_first_port", o_port, 0)
        `CHK("tie_first_cycle", o_cyc, 130)
        `CHK("tie_first_rdata", o_rdata, 32'hC2C3C0C1)
        t0_cyc = o_overlap;
        observe(0, 200);
        req1_a = 1'b0;
        `CHK("tie_second_port", o_port, 1)
        `CHK("tie_ack_spacing", o_cyc, 132)
        `CHK("tie_second_rdata", o_rdata, 32'hC3C2C1C0)
        `CHK("tie_second_cmd", fcmd_a, 32'h03000300)
        `CHK("tie_no_overlap", t0_cyc + o_overlap, 0)
        repeat (2) @(negedge ck);

        // Fairness: both held for four transfers
        addr0_a = 24'h000400; addr1_a = 24'h00AB12;
        req0_a = 1'b1; req1_a = 1'b1;
        observe(0, 200);
        `CHK("fair_port_0", o_port, 0)
        `CHK("fair_cycle_0", o_cyc, 130)
        `CHK("fair_rdata_0", o_rdata, 32'hC4C5C6C7)
        observe(0, 200);
        `CHK("fair_port_1", o_port, 1)
        `CHK("fair_cycle_1", o_cyc, 132)
        `CHK("fair_rdata_1", o_rdata, 32'h7D7C7B7A)
        `CHK("fair_cmd_1", fcmd_a, 32'h0300AB12)
        observe(0, 200);
        `CHK("fair_port_2", o_port, 0)
        `CHK("fair_cmd_2", fcmd_a, 32'h03000400)
        observe(0, 200);
        `CHK("fair_port_3", o_port, 1)
        `CHK("fair_cycle_3", o_cyc, 132)
        req0_a = 1'b0; req1_a = 1'b0;
        repeat (2) @(negedge ck);

        // Early drop of req1 at cycle 20 with req0 pending
        addr1_a = 24'h000300; req1_a = 1'b1;
        @(negedge ck);
        addr0_a = 24'h000100; req0_a = 1'b1;
        observe(0, 19);
        `CHK("drop_no_early_ack", o_port, -1)
        req1_a = 1'b0;
        observe(0, 200);
        `CHK("drop_ack_port", o_port, 1)
        `CHK("drop_ack_cycle", o_cyc, 110)
        `CHK("drop_rdata", o_rdata, 32'hC3C2C1C0)
        observe(0, 200);
        req0_a = 1'b0;
        `CHK("drop_next_port", o_port, 0)
        `CHK("drop_next_cycle", o_cyc, 132)
        `CHK("drop_next_rdata", o_rdata, 32'h44332211)
        repeat (2) @(negedge ck);

        // Reset at cycle 50 of a transfer
        addr0_a = 24'h000200; req0_a = 1'b1;
        observe(0, 50);
        `CHK("mid_no_ack_before", o_port, -1)
        `CHK("mid_cs_low_before", cs_a, 1'b0)
        rst_n = 1'b0;
        #1;
        `CHK("mid_rst_cs", cs_a, 1'b1)
        `CHK("mid_rst_sck", sck_a, 1'b0)
        `CHK("mid_rst_rdata", rdata_a, 32'h0)
        req0_a = 1'b0;
        observe(0, 5);
        `CHK("mid_rst_no_ack", o_port, -1)
        rst_n = 1'b1;
        repeat (4) @(negedge ck);
        `CHK("mid_after_no_ack", {ack0_a, ack1_a}, 2'b00)
        addr0_a = 24'h000100; req0_a = 1'b1;
        observe(0, 200);
        req0_a = 1'b0;
        `CHK("mid_fresh_cycle", o_cyc, 130)
        `CHK("mid_fresh_rdata", o_rdata, 32'h44332211)
        repeat (2) @(negedge ck);

        // Divider D=3 on instance B
        addr0_b = 24'h000100; req0_b = 1'b1;
        observe(1, 500);
        req0_b = 1'b0;
        `CHK("div_ack_cycle", o_cyc, 388)
        `CHK("div_port", o_port, 0)
        `CHK("div_rdata", o_rdata, 32'h44332211)
        `CHK("div_sck_rises", o_rise, 64)
        `CHK("div_cs_low", o_cs_low, 387)
        `CHK("div_hi_min", o_hi_min, 3)
        `CHK("div_hi_max", o_hi_max, 3)
        `CHK("div_hi_count", o_n_hi, 64)
        `CHK("div_lo_min", o_lo_min, 3)
        `CHK("div_lo_max", o_lo_max, 3)
        `CHK("div_lo_count", o_n_lo, 63)
        `CHK("div_setup_plus_low", o_first_lo, 6)
        `CHK("div_cmd", fcmd_b, 32'h03000100)
        repeat (4) @(negedge ck);
        `CHK("div_idle_busy", busy_b, 1'b0)

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/flash_arbiter.md
# flash_arbiter

- Shares the single SPI flash (FLASH_SCK/SSB/IO0/IO1) between two read requesters: instruction fetch (port 0) and a data/DMA reader (port 1).
- Arbitrates round-robin and runs one standard single-bit READ (0x03) per grant, returning a 32-bit little-endian word.
- Sits inside `dsp`, between the requesters and the flash pins. IO2/IO3 stay tied high at top level.

## Interface

Parameters:
- `CLK_DIV`, default 1: SCK half-period in `ck` cycles (D ≥ 1).
- `ADDR_W`, default 24: byte address width.

Ports:
- `ck`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req0` / `req1`  in  1  read request; held high until the matching ack
- `addr0` / `addr1`  in  ADDR_W  byte address, stable while req high
- `ack0` / `ack1`  out  1  one-cycle pulse; rdata valid in that cycle
- `rdata`  out  32  read word, shared by both ports
- `busy`  out  1  high from grant until return to IDLE
- `spi_sck`  out  1  flash clock, mode 0
- `spi_cs`  out  1  flash chip select, active low
- `spi_mosi`  out  1  flash data in
- `spi_miso`  in  1  flash data out

## Operation

- States: IDLE → SETUP → SHIFT → DONE → GAP → IDLE.
- IDLE
  - cs=1, sck=0.
  - If any req is high, grant one port, latch its address into a 32-bit shift word {0x03, addr}, set busy, go to SETUP.
- Arbitration
  - Only one req high: that port is granted.
  - Both high: the port not granted last time wins.
  - After reset, port 0 wins the first tie.
- SETUP
  - cs=0, sck=0, mosi = bit 31 of the shift word (0).
  - Lasts D cycles.
- SHIFT: 64 bits, 32 out then 32 in.
  - Each bit: SCK low for D cycles, then high for D cycles.
  - MOSI updates only when SCK goes low.
  - MISO is sampled in the ck cycle in which SCK goes high→low (end of the high phase).
  - Bits 0–31 shift out cmd+addr MSB first. MOSI is 0 during bits 32–63.
  - Bits 32–63 shift in four bytes, each MSB first. Byte k (k = 0..3) lands in rdata[8k+7:8k], so the flash byte at addr goes to rdata[7:0].
- DONE
  - 1 cycle: cs=1, sck=0, granted ack pulses high, rdata valid.
  - rdata holds its value until the next DONE.
- GAP
  - cs=1 for D cycles, then IDLE and busy=0.
  - A req still high at IDLE is treated as a new request.
- A granted transfer always completes. Deasserting req mid-transfer does not abort it; the ack still pulses.
- The non-granted req waits with no side effects.
- Address bits above 24 are ignored. Narrower ADDR_W is zero-extended.

## Timing

- Reset (async assert, sync release):
  - cs=1, sck=0, mosi=0, ack0=ack1=0, rdata=0, busy=0.
  - State IDLE, tie priority to port 0.
- Reset mid-transfer: cs goes high immediately and the transfer is dropped, with no ack.
- Latency (cycle 0 = first cycle a req is seen in IDLE):
  - SETUP occupies cycles 1..D.
  - SHIFT occupies cycles D+1..129D.
  - ack is high in cycle 129D+1.
  - D=1: ack in cycle 130.
- Throughput: next IDLE is cycle 130D+2. Back-to-back requests complete every 130D+2 cycles.
- cs low for exactly 129D cycles per transfer; 64 SCK rising edges per transfer.
- ack0 and ack1 never high together. busy is high in every cycle where cs=0.

## Test plan

- Single read: flash model holds 0x11,0x22,0x33,0x44 at 0x000100; req0 with addr0=0x000100, D=1.
  - MOSI carries 0x03,0x00,0x01,0x00.
  - ack0 in cycle 130 with rdata=0x44332211.
  - 64 SCK edges; cs low for 129 cycles.
- Tie after reset: req0 and req1 raised in the same cycle.
  - Port 0 served first, then port 1.
  - Two acks 132 cycles apart; ack1 never overlaps ack0.
- Fairness: req0 held continuously with req1 also held.
  - Grants alternate 0,1,0,1 over 4 transfers; no port served twice in a row while the other waits.
- Divider: CLK_DIV=3, one read.
  - ack in cycle 388; SCK high and low phases each exactly 3 cycles; MISO sampled at the end of each high phase.
- Reset mid-transfer: assert rst_n low at cycle 50 of a transfer.
  - cs=1 and sck=0 in the same cycle; no ack.
  - After release, a fresh req0 completes normally.
- Early drop: req1 deasserted at cycle 20 of its transfer.
  - Transfer completes and ack1 still pulses.
  - A req0 pending throughout is granted at the following IDLE.
